// File: rtl/wdt_ovf_monitor.sv
// Multi-channel counter overflow monitor: spots terminal->wrap transitions on
// external up/down counters, counts them with saturation and raises sticky alarms.

module wdt_ovf_ch #(
  parameter int CNT_W = 32,
  parameter int OVF_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [OVF_W-1:0] thr_i,
  input  logic             clr_i,
  output logic             ovf_pulse_o,
  output logic [OVF_W-1:0] ovf_cnt_o,
  output logic             alarm_o
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ARMED = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             dir_q;
  logic [CNT_W-1:0] term, wrap;
  logic             live, evt;
  logic [OVF_W-1:0] cnt_inc;

  // A sample only counts when enabled, direction is stable and no clear is pending.
  assign term    = dir_q ? '0 : '1;
  assign wrap    = ~term;
  assign live    = en_i && (dir_i == dir_q) && !clr_i;
  assign evt     = live && (state_q == ARMED) && (cnt_i == wrap);
  assign cnt_inc = (&ovf_cnt_o) ? ovf_cnt_o : ovf_cnt_o + 1'b1;

  always_comb begin
    state_d = IDLE;
    if (live && (cnt_i == term)) state_d = ARMED;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      dir_q       <= 1'b0;
      ovf_pulse_o <= 1'b0;
      ovf_cnt_o   <= '0;
      alarm_o     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_i;
      ovf_pulse_o <= evt;
      if (clr_i) begin
        ovf_cnt_o <= '0;
        alarm_o   <= 1'b0;
      end else if (evt) begin
        ovf_cnt_o <= cnt_inc;
        if ((thr_i != '0) && (cnt_inc >= thr_i)) alarm_o <= 1'b1;
      end
    end
  end
endmodule

module wdt_ovf_monitor #(
  parameter int CNT_W = 32,
  parameter int N_CH  = 4,
  parameter int OVF_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [N_CH-1:0]       en_i,
  input  logic [N_CH-1:0]       dir_i,
  input  logic [N_CH*CNT_W-1:0] cnt_i,
  input  logic [OVF_W-1:0]      thr_i,
  input  logic [N_CH-1:0]       clr_i,
  output logic [N_CH-1:0]       ovf_pulse_o,
  output logic [N_CH*OVF_W-1:0] ovf_cnt_o,
  output logic [N_CH-1:0]       alarm_o,
  output logic                  alarm_any_o
);
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    wdt_ovf_ch #(.CNT_W(CNT_W), .OVF_W(OVF_W)) u_ch (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .en_i       (en_i[c]),
      .dir_i      (dir_i[c]),
      .cnt_i      (cnt_i[c*CNT_W +: CNT_W]),
      .thr_i      (thr_i),
      .clr_i      (clr_i[c]),
      .ovf_pulse_o(ovf_pulse_o[c]),
      .ovf_cnt_o  (ovf_cnt_o[c*OVF_W +: OVF_W]),
      .alarm_o    (alarm_o[c])
    );
  end

  assign alarm_any_o = |alarm_o;
endmodule

// File: tb/tb_wdt_ovf_monitor.sv
// Random + directed bench for wdt_ovf_monitor against a sample-history reference model.

module tb_wdt_ovf_monitor;
  localparam int CNT_W = 32;
  localparam int N_CH  = 4;
  localparam int OVF_W = 4;
  localparam int MAXV  = (1 << OVF_W) - 1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [N_CH-1:0]       en, dir, clr;
  logic [N_CH-1:0][CNT_W-1:0] cnt;
  logic [OVF_W-1:0]      thr;
  logic [N_CH-1:0]       pulse, alarm;
  logic [N_CH*OVF_W-1:0] ovf_cnt;
  logic                  alarm_any;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: an event is a wrap sample whose previous sample was terminal, both accepted.
  bit             m_prev_ok [N_CH];
  logic [CNT_W-1:0] m_prev  [N_CH];
  bit             m_dir     [N_CH];
  int             m_cnt     [N_CH];
  bit             m_alarm   [N_CH];
  bit             m_pulse   [N_CH];

  wdt_ovf_monitor #(.CNT_W(CNT_W), .N_CH(N_CH), .OVF_W(OVF_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .dir_i(dir), .cnt_i(cnt),
    .thr_i(thr), .clr_i(clr), .ovf_pulse_o(pulse), .ovf_cnt_o(ovf_cnt),
    .alarm_o(alarm), .alarm_any_o(alarm_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CNT_W-1:0] ones();
    logic [CNT_W-1:0] v;
    v = '1;
    return v;
  endfunction

  task automatic model_step();
    logic [CNT_W-1:0] term, wrap;
    bit acc, ev;
    for (int c = 0; c < N_CH; c++) begin
      if (!rst_n) begin
        m_prev_ok[c] = 0; m_dir[c] = 0; m_cnt[c] = 0; m_alarm[c] = 0; m_pulse[c] = 0;
      end else begin
        term = dir[c] ? '0 : ones();
        wrap = dir[c] ? ones() : '0;
        acc  = en[c] && (dir[c] == m_dir[c]) && !clr[c];
        ev   = acc && m_prev_ok[c] && (m_prev[c] == term) && (cnt[c] == wrap);
        m_pulse[c] = ev;
        if (clr[c]) begin
          m_cnt[c] = 0; m_alarm[c] = 0;
        end else if (ev) begin
          m_cnt[c] = (m_cnt[c] + 1 > MAXV) ? MAXV : m_cnt[c] + 1;
          if (thr != 0 && m_cnt[c] >= int'(thr)) m_alarm[c] = 1;
        end
        m_prev_ok[c] = acc;
        m_prev[c]    = cnt[c];
        m_dir[c]     = dir[c];
      end
    end
  endtask

  task automatic step(input string tag);
    logic [N_CH-1:0]       e_pulse, e_alarm;
    logic [N_CH*OVF_W-1:0] e_cnt;
    @(posedge clk);
    model_step();
    #1;
    for (int c = 0; c < N_CH; c++) begin
      e_pulse[c] = m_pulse[c];
      e_alarm[c] = m_alarm[c];
      e_cnt[c*OVF_W +: OVF_W] = OVF_W'(m_cnt[c]);
    end
    chk({tag, "_pulse"}, 64'(pulse), 64'(e_pulse));
    chk({tag, "_cnt"},   64'(ovf_cnt), 64'(e_cnt));
    chk({tag, "_alarm"}, 64'(alarm), 64'(e_alarm));
    chk({tag, "_any"},   64'(alarm_any), 64'(|e_alarm));
  endtask

  task automatic idle_inputs();
    en = '1; dir = '0; clr = '0; thr = '0;
    for (int c = 0; c < N_CH; c++) cnt[c] = CNT_W'(5);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step("rst");
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    do_reset();
    do_reset();

    // Up wrap on ch0
    cnt[0] = 32'hFFFF_FFFE; step("up0");
    cnt[0] = 32'hFFFF_FFFF; step("up1");
    cnt[0] = 32'h0000_0000; step("up2");
    chk("up_pulse_ch0", 64'(pulse), 64'h1);
    chk("up_cnt", 64'(ovf_cnt), 64'h1);
    cnt[0] = CNT_W'(5); step("up3");
    chk("up_pulse_once", 64'(pulse), 64'h0);

    // Down wrap with a gap, ch1
    dir[1] = 1'b1; cnt[1] = CNT_W'(5); step("dn_dir");
    cnt[1] = '0;          step("dn0");
    cnt[1] = CNT_W'(5);   step("dn1");
    cnt[1] = ones();      step("dn2");
    chk("dn_gap_nopulse", 64'(pulse[1]), 64'h0);
    cnt[1] = '0;          step("dn3");
    cnt[1] = ones();      step("dn4");
    chk("dn_pulse", 64'(pulse[1]), 64'h1);
    chk("dn_cnt1", 64'(ovf_cnt[1*OVF_W +: OVF_W]), 64'h1);

    // Saturation and alarm on ch2
    thr = OVF_W'(3);
    for (int i = 0; i < 20; i++) begin
      cnt[2] = ones(); step("sat_t");
      cnt[2] = '0;     step("sat_w");
      if (i == 1) chk("alarm_pre3", 64'(alarm[2]), 64'h0);
      if (i == 2) chk("alarm_at3", 64'(alarm[2]), 64'h1);
    end
    chk("sat_cnt", 64'(ovf_cnt[2*OVF_W +: OVF_W]), 64'(MAXV));
    chk("sat_any", 64'(alarm_any), 64'h1);
    thr = OVF_W'(0); step("thr_chg");
    chk("thr_no_retro", 64'(alarm[2]), 64'h1);

    // Clear beats a simultaneous event on ch3
    cnt[3] = ones(); step("clr_t");
    cnt[3] = '0; step("clr_w0");
    cnt[3] = ones(); step("clr_t2");
    cnt[3] = '0; clr[3] = 1'b1; step("clr_w");
    chk("clr_pulse", 64'(pulse[3]), 64'h0);
    chk("clr_cnt", 64'(ovf_cnt[3*OVF_W +: OVF_W]), 64'h0);
    clr[3] = 1'b0;

    // Disable and direction flip between terminal and wrap
    cnt[0] = ones(); step("dis_t");
    en[0] = 1'b0; cnt[0] = '0; step("dis_w");
    chk("dis_pulse", 64'(pulse[0]), 64'h0);
    en[0] = 1'b1;
    cnt[0] = ones(); step("flip_t");
    dir[0] = 1'b1; cnt[0] = '0; step("flip_w");
    chk("flip_pulse", 64'(pulse[0]), 64'h0);
    chk("flip_cnt", 64'(ovf_cnt[0 +: OVF_W]), 64'h1);
    dir[0] = 1'b0; step("flip_back");

    // Reset while armed
    cnt[0] = ones(); step("mr_t");
    rst_n = 1'b0; step("mr_rst");
    rst_n = 1'b1; cnt[0] = '0; step("mr_w");
    chk("mr_pulse", 64'(pulse), 64'h0);
    chk("mr_cnt", 64'(ovf_cnt), 64'h0);
    chk("mr_alarm", 64'(alarm), 64'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N_CH; c++) begin
        case ($urandom_range(0, 3))
          0: cnt[c] = '0;
          1: cnt[c] = ones();
          2: cnt[c] = CNT_W'($urandom);
          default: ;
        endcase
        en[c]  = ($urandom_range(0, 15) != 0);
        clr[c] = ($urandom_range(0, 40) == 0);
        if ($urandom_range(0, 30) == 0) dir[c] = ~dir[c];
      end
      if ($urandom_range(0, 50) == 0) thr = OVF_W'($urandom);
      rst_n = ($urandom_range(0, 300) != 0);
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
